// File: rtl/ram_bank_arbiter.sv
// Two-requester arbiter for a shared two-bank 8-bit RAM: round-robin with a burst
// cap, registered bank command, and tagged read-data return to the issuing requester.
module ram_bank_arbiter #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned HOLD_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_a,
  input  logic              req_b,
  input  logic              we_a,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [7:0]        wdata_a,
  input  logic [7:0]        wdata_b,
  output logic              gnt_a,
  output logic              gnt_b,
  output logic              rvalid_a,
  output logic              rvalid_b,
  output logic [7:0]        rdata_a,
  output logic [7:0]        rdata_b,
  output logic              ram_en,
  output logic              ram_we,
  output logic              ram_sel,
  output logic [ADDR_W-2:0] ram_addr,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata_1,
  input  logic [7:0]        ram_rdata_2
);

  localparam int unsigned CNT_W = $clog2(HOLD_MAX + 1);
  localparam logic [CNT_W-1:0] HOLD_CNT = CNT_W'(HOLD_MAX);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              last, last_nxt;   // 0 = A owned last, 1 = B owned last
  logic              grant_a, grant_b;
  logic              xfer;
  logic              cmd_we;
  logic [ADDR_W-1:0] cmd_addr;
  logic [7:0]        cmd_wdata;
  logic              t1_vld, t1_own, t1_bank;
  logic              t2_vld, t2_own, t2_bank;
  logic [7:0]        ret_data;

  // State, burst counter and fairness flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      last  <= 1'b1;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      last  <= last_nxt;
    end
  end

  // Grant decision; the cap is only consulted while the other side is waiting
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    last_nxt  = last;
    grant_a   = 1'b0;
    grant_b   = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_a && (!req_b || last)) begin
          grant_a   = 1'b1;
          state_nxt = OWN_A;
          cnt_nxt   = ONE_CNT;
        end else if (req_b) begin
          grant_b   = 1'b1;
          state_nxt = OWN_B;
          cnt_nxt   = ONE_CNT;
        end
      end
      OWN_A: begin
        if (req_a && (!req_b || cnt < HOLD_CNT)) begin
          grant_a = 1'b1;
          if (cnt != HOLD_CNT) cnt_nxt = cnt + ONE_CNT;
        end else if (req_b) begin
          grant_b   = 1'b1;
          state_nxt = OWN_B;
          cnt_nxt   = ONE_CNT;
          last_nxt  = 1'b0;
        end else begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          last_nxt  = 1'b0;
        end
      end
      OWN_B: begin
        if (req_b && (!req_a || cnt < HOLD_CNT)) begin
          grant_b = 1'b1;
          if (cnt != HOLD_CNT) cnt_nxt = cnt + ONE_CNT;
        end else if (req_a) begin
          grant_a   = 1'b1;
          state_nxt = OWN_A;
          cnt_nxt   = ONE_CNT;
          last_nxt  = 1'b1;
        end else begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          last_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Grants are suppressed while reset is asserted
  assign gnt_a = grant_a & rst_n;
  assign gnt_b = grant_b & rst_n;
  assign xfer  = gnt_a | gnt_b;

  assign cmd_we    = gnt_b ? we_b    : we_a;
  assign cmd_addr  = gnt_b ? addr_b  : addr_a;
  assign cmd_wdata = gnt_b ? wdata_b : wdata_a;

  // Registered RAM command; address/data fields hold when idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_sel   <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else begin
      ram_en <= xfer;
      ram_we <= xfer & cmd_we;
      if (xfer) begin
        ram_sel   <= cmd_addr[ADDR_W-1];
        ram_addr  <= cmd_addr[ADDR_W-2:0];
        ram_wdata <= cmd_wdata;
      end
    end
  end

  // Read tag pipeline (valid, owner, bank) aligned with the RAM read latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t1_vld  <= 1'b0;
      t1_own  <= 1'b0;
      t1_bank <= 1'b0;
      t2_vld  <= 1'b0;
      t2_own  <= 1'b0;
      t2_bank <= 1'b0;
    end else begin
      t1_vld  <= xfer & ~cmd_we;
      t1_own  <= gnt_b;
      t1_bank <= cmd_addr[ADDR_W-1];
      t2_vld  <= t1_vld;
      t2_own  <= t1_own;
      t2_bank <= t1_bank;
    end
  end

  assign ret_data = t2_bank ? ram_rdata_2 : ram_rdata_1;

  // Steer returning read data to its requester
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_a <= 1'b0;
      rvalid_b <= 1'b0;
      rdata_a  <= '0;
      rdata_b  <= '0;
    end else begin
      rvalid_a <= t2_vld & ~t2_own;
      rvalid_b <= t2_vld & t2_own;
      if (t2_vld && !t2_own) rdata_a <= ret_data;
      if (t2_vld && t2_own)  rdata_b <= ret_data;
    end
  end

endmodule

// File: doc/ram_bank_arbiter.md
# ram_bank_arbiter

Arbitrates one shared two-bank 8-bit RAM between two requesters: port A (processor) and port B (loader/DMA peripheral). Each cycle it grants at most one access, using round-robin with a burst cap. It decodes the address MSB into the bank select and issues a registered command to both banks. It then steers the selected bank's synchronous read data back to the requester that issued the read, with a valid strobe. The block sits between the requesters and the two RAM banks and replaces ad-hoc read-strobe bank muxing.

## Interface
- ADDR_W, 8, requester address width; MSB selects bank, low ADDR_W-1 bits address within bank
- HOLD_MAX, 4, max consecutive grants to one owner while the other is requesting (≥1)
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_a / req_b  in  1  access request; held until granted
- we_a / we_b  in  1  1 = write, 0 = read; qualified by req
- addr_a / addr_b  in  ADDR_W  access address
- wdata_a / wdata_b  in  8  write data
- gnt_a / gnt_b  out  1  combinational grant; access transfers at the clk edge where req&gnt
- rvalid_a / rvalid_b  out  1  one-cycle read-return strobe
- rdata_a / rdata_b  out  8  read data; holds its value between strobes
- ram_en  out  1  registered RAM access enable
- ram_we  out  1  registered write enable
- ram_sel  out  1  bank select (0 = bank 1, 1 = bank 2) = addr[ADDR_W-1]
- ram_addr  out  ADDR_W-1  in-bank address
- ram_wdata  out  8  write data
- ram_rdata_1 / ram_rdata_2  in  8  bank read data, valid one cycle after ram_en

## Operation
- FSM states: IDLE, OWN_A, OWN_B. Registers: burst counter cnt (width clog2(HOLD_MAX+1), saturating) and last-owner flag last.
- IDLE:
  - Only one req: grant it → OWN_x, cnt=1.
  - Both req: grant the requester ≠ last → OWN_x, cnt=1.
  - None: stay.
- OWN_A:
  - req_a and (!req_b or cnt<HOLD_MAX): gnt_a, cnt++.
  - Else if req_b: gnt_b → OWN_B, cnt=1, last=A.
  - Else: no grant → IDLE, last=A.
- OWN_B: symmetric to OWN_A.
- gnt_a and gnt_b are never both high. No grant when no req. No bubble cycle on owner switch.
- On a granted transfer, the next edge registers ram_en=1, ram_we=we_x, ram_sel=addr_x MSB, ram_addr=addr_x low bits, ram_wdata=wdata_x. Without a transfer, ram_en=0 and ram_we=0; the other command fields hold.
- Reads carry a 2-stage tag (valid, owner, bank) through the pipeline. On return, data comes from ram_rdata_1 if bank=0, else ram_rdata_2. It is registered into rdata_owner, and rvalid_owner pulses.
- Writes produce no rvalid.

## Timing
- Cycle T: req_x=1, gnt_x=1 (combinational) → transfer at end of T.
- T+1: ram_en/ram_we/ram_sel/ram_addr/ram_wdata valid.
- T+2: ram_rdata_n valid.
- T+3: rdata_x valid, rvalid_x=1 for exactly one cycle. Read latency is 3 cycles from the grant cycle.
- Fully pipelined: one access per cycle sustained. Back-to-back reads return in grant order, one per cycle.
- Reset values: gnt_*=0, rvalid_*=0, rdata_*=0x00, ram_en=0, ram_we=0, ram_sel=0, ram_addr=0, ram_wdata=0. State IDLE, cnt=0, last=B (A wins the first contention).
- Reset mid-operation: all in-flight tags are cleared. No rvalid is produced for reads granted before rst_n deasserts.
- cnt saturates at HOLD_MAX. It is never compared in single-requester cycles, so an uncontested owner keeps the grant indefinitely.
- A write then a read to the same address: the read returns the new data. This relies on RAM write-first or ordering guaranteed by the one-command-per-cycle pipeline.

## Test plan
- Reset: rst_n=0 with random inputs → all outputs 0. Release, then req_a and req_b asserted together → gnt_a first.
- Single read: A reads addr 0x85, bank 2 returns 0x3C → T+1: ram_en=1, ram_we=0, ram_sel=1, ram_addr=0x05; T+3: rvalid_a=1, rdata_a=0x3C; rvalid_b stays 0.
- Contention: req_a and req_b held high for 16 cycles from IDLE, HOLD_MAX=4 → grant sequence AAAABBBBAAAABBBB, never both.
- Write: B writes 0xAA to addr 0x12 → T+1: ram_en=1, ram_we=1, ram_sel=0, ram_addr=0x12, ram_wdata=0xAA; no rvalid_b.
- Fairness memory: A alone for 2 cycles, one idle cycle, then both request → B granted first (last=A).
- Reset mid-read: A read granted, rst_n pulsed low in T+1 → rvalid_a never asserts, rdata_a=0x00.
